// File: rtl/reg_pipe_hs.sv
// ============================================================================
// Module   : reg_pipe_hs
// Brief    : WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble
//            collapse, flush and occupancy. Optional parity: REG_PIPE_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_pipe_hs #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef REG_PIPE_PARITY_EN
  ,
  input  logic                       in_par,
  output logic                       par_err
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic [OCC_W-1:0] r_occ;
  logic             w_xfer_in;
  logic             w_xfer_out;

  // A stage may advance unless it and every stage downstream are full and
  // the output is stalled; flattened so there is no combinational chain.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      assign w_adv[k] = out_ready | ~(&r_v[DEPTH-1:k]);
      if (k == 0) begin : g_head
        assign w_src_v[k] = in_valid;
        assign w_src_d[k] = in_data;
      end else begin : g_body
        assign w_src_v[k] = r_v[k-1];
        assign w_src_d[k] = r_d[k-1];
      end
    end
  endgenerate

  assign in_ready   = w_adv[0];
  assign out_valid  = r_v[DEPTH-1];
  assign out_data   = r_d[DEPTH-1];
  assign occupancy  = r_occ;
  assign w_xfer_in  = in_valid & w_adv[0];
  assign w_xfer_out = r_v[DEPTH-1] & out_ready;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          r_v[k] <= 1'b0;
        end else if (w_adv[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) begin
            r_d[k] <= w_src_d[k];
          end
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_xfer_in && !w_xfer_out) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_xfer_in && w_xfer_out) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] r_p;
  logic [DEPTH-1:0] w_src_p;
  logic             r_par_err;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_par
      if (k == 0) begin : g_head
        assign w_src_p[k] = in_par;
      end else begin : g_body
        assign w_src_p[k] = r_p[k-1];
      end
    end
  endgenerate

  always_ff @(posedge ck) begin
    if (rst) begin
      r_p <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!flush && w_adv[k] && w_src_v[k]) begin
          r_p[k] <= w_src_p[k];
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst || flush) begin
      r_par_err <= 1'b0;
    end else if (w_xfer_out && ((^r_d[DEPTH-1]) != r_p[DEPTH-1])) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe_hs.sv
// ============================================================================
// Module   : tb_reg_pipe_hs
// Brief    : Directed scoreboard bench for reg_pipe_hs (DEPTH=4, WIDTH=16).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_pipe_hs;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic                       ck = 1'b0;
  logic                       rst = 1'b1;
  logic                       flush = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`ifdef REG_PIPE_PARITY_EN
  logic                       in_par = 1'b0;
  logic                       par_err;
  logic                       par_flip = 1'b0;
`endif

  reg_pipe_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ck        (ck),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef REG_PIPE_PARITY_EN
    ,
    .in_par    (in_par),
    .par_err   (par_err)
`endif
  );

  always #5 ck = ~ck;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out = 0;
  int occ_peak = 0;
  logic [WIDTH-1:0] exp_q[$];
  int in_edges[$];
  int out_edges[$];

  always @(posedge ck) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected beat on every output transfer; records
  // accepted input beats; rst/flush discard everything in flight.
  always @(negedge ck) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h expected no beat", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      out_edges.push_back(cyc);
      n_out++;
    end
    if (rst || flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(in_data);
      in_edges.push_back(cyc + 1);
    end
    if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic at_neg();
    @(negedge ck);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
`ifdef REG_PIPE_PARITY_EN
    in_par   = (^d) ^ par_flip;
`endif
    at_neg();
    while (!in_ready && n < 40) begin
      at_neg();
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      at_neg();
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    at_neg();
  endtask

  int n0;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    at_neg();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Back-to-back stream through an empty pipe
    tick();
    out_ready = 1'b1;
    in_edges.delete();
    out_edges.delete();
    occ_peak = 0;
    for (int i = 1; i <= 8; i++) send(WIDTH'(i));
    drain();
    chk("t1_count",   32'(out_edges.size()), 32'd8);
    chk("t1_latency", 32'(out_edges[0] - in_edges[0]), 32'(DEPTH - 1));
    chk("t1_span",    32'(out_edges[7] - out_edges[0]), 32'd7);
    chk("t1_peak",    32'(occ_peak), 32'd4);

    // Backpressure: fill, hold, release
    tick();
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 1; i <= 4; i++) send(WIDTH'(i));
    at_neg();
    chk("t2_full_occ",   32'(occupancy), 32'd4);
    chk("t2_full_ready", 32'(in_ready),  32'd0);
    chk("t2_full_valid", 32'(out_valid), 32'd1);
    chk("t2_full_data",  32'(out_data),  32'h1);
    tick();
    in_valid = 1'b1;
    in_data  = 16'h0005;
`ifdef REG_PIPE_PARITY_EN
    in_par   = ^in_data;
`endif
    repeat (3) at_neg();
    chk("t2_stall_ready", 32'(in_ready),  32'd0);
    chk("t2_stall_occ",   32'(occupancy), 32'd4);
    tick();
    out_ready = 1'b1;
    at_neg();
    chk("t2_release_ready", 32'(in_ready),  32'd1);
    chk("t2_release_occ",   32'(occupancy), 32'd4);
    tick();
    in_valid = 1'b0;
    at_neg();
    chk("t2_swap_occ", 32'(occupancy), 32'd4);
    tick();
    send(16'h0006);
    drain();
    chk("t2_count", 32'(n_out - n0), 32'd6);

    // Gapped input under stall: bubbles collapse
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0021;
`ifdef REG_PIPE_PARITY_EN
    in_par   = ^in_data;
`endif
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 16'h0023;
`ifdef REG_PIPE_PARITY_EN
    in_par   = ^in_data;
`endif
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    at_neg();
    chk("t3_occ",   32'(occupancy), 32'd2);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data",  32'(out_data),  32'h21);
    chk("t3_ready", 32'(in_ready),  32'd1);
    out_edges.delete();
    tick();
    out_ready = 1'b1;
    drain();
    chk("t3_count",    32'(out_edges.size()), 32'd2);
    chk("t3_adjacent", 32'(out_edges[1] - out_edges[0]), 32'd1);

    // Flush a full pipe with a beat offered
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(WIDTH'(16'h0031 + i));
    in_valid = 1'b1;
    in_data  = 16'h0035;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    at_neg();
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_occ",   32'(occupancy), 32'd0);
    chk("t4_ready", 32'(in_ready),  32'd1);
    chk("t4_data_held", 32'(out_data), 32'h31);
    n0 = n_out;
    tick();
    out_ready = 1'b1;
    repeat (8) at_neg();
    chk("t4_no_out", 32'(n_out - n0), 32'd0);

    // Reset mid-stream, then a fresh beat
    tick();
    send(16'h0041);
    send(16'h0042);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_data",  32'(out_data),  32'd0);
    chk("t5_occ",   32'(occupancy), 32'd0);
    chk("t5_ready", 32'(in_ready),  32'd1);
    in_edges.delete();
    out_edges.delete();
    tick();
    send(16'hBEEF);
    drain();
    chk("t5_count",   32'(out_edges.size()), 32'd1);
    chk("t5_latency", 32'(out_edges[0] - in_edges[0]), 32'(DEPTH - 1));

`ifdef REG_PIPE_PARITY_EN
    tick();
    send(16'h0005);
    drain();
    chk("t6_par_clean", 32'(par_err), 32'd0);
    tick();
    par_flip = 1'b1;
    send(16'h0003);
    par_flip = 1'b0;
    drain();
    chk("t6_par_set", 32'(par_err), 32'd1);
    repeat (3) at_neg();
    chk("t6_par_sticky", 32'(par_err), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    at_neg();
    chk("t6_par_flush", 32'(par_err), 32'd0);
`endif

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
